stg_if_fq: RTL and testbench

- Instruction fetch stage with an in-order fetch queue.
- Issues word-addressed reads to instruction memory and buffers the returned words with their addresses.
- Presents one pc/instr pair per cycle to the decode stage and honours the decode-side stall and flush controls.
- On a flush, it redirects to a new PC and discards all in-flight and queued fetches.

---
 rtl/stg_if_fq.sv | 166 ++++++++++++++++
 tb/tb_stg_if_fq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stg_if_fq.sv
// Instruction fetch stage: credit-limited word fetches into an in-order queue whose head feeds decode.
// Define STG_IF_PERF_EN to add saturating fetched/bubble performance counters.
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module stg_if_fq #(
  parameter int unsigned           FQ_DEPTH  = 4,
  parameter int unsigned           MAX_OUTST = 2,
  parameter logic [`SIZE_ADDR-1:0] RESET_PC  = '0
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  output logic                  ow_mem_req,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr,
  input  logic                  iw_mem_gnt,
  input  logic                  iw_mem_rvalid,
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata,
  output logic [`SIZE_ADDR-1:0] ow_pc,
  output logic [`SIZE_DATA-1:0] ow_instr,
  output logic                  ow_valid,
  input  logic                  iw_stall,
  input  logic                  iw_flush,
  input  logic [`SIZE_ADDR-1:0] iw_flush_pc
`ifdef STG_IF_PERF_EN
  ,
  output logic [31:0]           ow_perf_fetched,
  output logic [31:0]           ow_perf_bubble
`endif
);

  localparam int unsigned AW = `SIZE_ADDR;
  localparam int unsigned DW = `SIZE_DATA;
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FQ_DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);

  logic [AW-1:0] entry_pc_q    [FQ_DEPTH];
  logic [DW-1:0] entry_instr_q [FQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic          run_q;

  logic [CW:0] credit_sum;
  logic        fq_valid, accept, resp, push, pop;

  // run_q keeps the request low in the first cycle after reset release.
  assign credit_sum = {1'b0, occ_q} + {1'b0, outst_q};
  assign ow_mem_req = run_q && !iw_flush && (credit_sum < DEPTH_C) &&
                      (outst_q < MAX_C) && (drop_q == '0);
  assign ow_mem_addr = fetch_pc_q;

  assign fq_valid = (occ_q != '0);
  assign accept   = ow_mem_req && iw_mem_gnt;
  assign resp     = iw_mem_rvalid && (outst_q != '0);
  assign push     = resp && (drop_q == '0) && !iw_flush;
  assign pop      = fq_valid && !iw_stall && !iw_flush;

  assign ow_valid = fq_valid;
  assign ow_pc    = fq_valid ? entry_pc_q[rd_ptr_q] : '0;
  assign ow_instr = fq_valid ? entry_instr_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;

    if (accept && !resp) begin
      outst_d = outst_q + CW'(1);
    end else if (!accept && resp) begin
      outst_d = outst_q - CW'(1);
    end

    if (iw_flush) begin
      // Everything still in flight must be swallowed before refetching.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      drop_d     = resp ? outst_q - CW'(1) : outst_q;
      fetch_pc_d = iw_flush_pc;
      resp_pc_d  = iw_flush_pc;
    end else begin
      if (resp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (accept) begin
        fetch_pc_d = fetch_pc_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        occ_d = occ_q + CW'(1);
      end else if (!push && pop) begin
        occ_d = occ_q - CW'(1);
      end
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      run_q      <= 1'b0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        entry_pc_q[i]    <= '0;
        entry_instr_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      run_q      <= 1'b1;
      if (push) begin
        entry_pc_q[wr_ptr_q]    <= resp_pc_q;
        entry_instr_q[wr_ptr_q] <= iw_mem_rdata;
      end
    end
  end

`ifdef STG_IF_PERF_EN
  logic [31:0] perf_fetched_q, perf_bubble_q;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      if (pop && (perf_fetched_q != '1)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (!fq_valid && !iw_stall && !iw_flush && (perf_bubble_q != '1)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign ow_perf_fetched = perf_fetched_q;
  assign ow_perf_bubble  = perf_bubble_q;
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_stg_if_fq.sv
// Directed bench for stg_if_fq with an in-order, fixed-latency memory responder.
`timescale 1ns/1ps
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_stg_if_fq;
  localparam int AW = `SIZE_ADDR;
  localparam int DW = `SIZE_DATA;

  logic          iw_clk = 1'b0;
  logic          iw_rst_n = 1'b0;
  logic          ow_mem_req;
  logic [AW-1:0] ow_mem_addr;
  logic          iw_mem_gnt = 1'b1;
  logic          iw_mem_rvalid;
  logic [DW-1:0] iw_mem_rdata;
  logic [AW-1:0] ow_pc;
  logic [DW-1:0] ow_instr;
  logic          ow_valid;
  logic          iw_stall = 1'b0;
  logic          iw_flush = 1'b0;
  logic [AW-1:0] iw_flush_pc = '0;
`ifdef STG_IF_PERF_EN
  logic [31:0]   ow_perf_fetched, ow_perf_bubble;
  logic [31:0]   bub_before;
`endif

  int checks = 0;
  int errors = 0;
  int pops = 0;

  stg_if_fq dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n),
    .ow_mem_req(ow_mem_req), .ow_mem_addr(ow_mem_addr), .iw_mem_gnt(iw_mem_gnt),
    .iw_mem_rvalid(iw_mem_rvalid), .iw_mem_rdata(iw_mem_rdata),
    .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_valid(ow_valid),
    .iw_stall(iw_stall), .iw_flush(iw_flush), .iw_flush_pc(iw_flush_pc)
`ifdef STG_IF_PERF_EN
    , .ow_perf_fetched(ow_perf_fetched), .ow_perf_bubble(ow_perf_bubble)
`endif
  );

  // Clock / reset block
  always #5 iw_clk = ~iw_clk;

  task automatic tick();
    @(posedge iw_clk);
    #2;
  endtask

  task automatic do_reset(input int lat, input logic gnt);
    iw_rst_n = 1'b0;
    iw_stall = 1'b0;
    iw_flush = 1'b0;
    iw_mem_gnt = gnt;
    mem_en = 1'b1;
    mem_lat = lat;
    tick();
    tick();
    iw_rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (ow_valid) break;
      tick();
      #1;
    end
  endtask

  // Memory responder: accepts sampled mid-cycle, data = addr + 0x100 after mem_lat cycles
  logic          mem_en = 1'b1;
  int unsigned   mem_lat = 1;
  int unsigned   cyc_n = 0;
  logic [AW-1:0] pend_a[$];
  int unsigned   pend_t[$];

  initial begin
    logic [AW-1:0] a;
    iw_mem_rvalid = 1'b0;
    iw_mem_rdata = '0;
    forever begin
      @(negedge iw_clk);
      if (!iw_rst_n) begin
        pend_a.delete();
        pend_t.delete();
      end else if (mem_en && ow_mem_req && iw_mem_gnt) begin
        pend_a.push_back(ow_mem_addr);
        pend_t.push_back(cyc_n + mem_lat);
      end
      @(posedge iw_clk);
      #1;
      cyc_n++;
      if (mem_en) begin
        iw_mem_rvalid = 1'b0;
        if (pend_t.size() > 0 && pend_t[0] <= cyc_n) begin
          a = pend_a.pop_front();
          void'(pend_t.pop_front());
          iw_mem_rvalid = 1'b1;
          iw_mem_rdata = DW'(a) + 32'h100;
        end
      end
    end
  end

  // Pop monitor for the performance counter
  always @(negedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) pops = 0;
    else if (ow_valid && !iw_stall && !iw_flush) pops = pops + 1;
  end

  task automatic test_reset();
    iw_rst_n = 1'b0;
    iw_mem_gnt = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (ow_mem_req !== 1'b0 || ow_mem_addr !== '0 || ow_valid !== 1'b0 ||
        ow_pc !== '0 || ow_instr !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b pc=%h instr=%h want 0/0/0/0/0",
               ow_mem_req, ow_mem_addr, ow_valid, ow_pc, ow_instr);
    end
    iw_rst_n = 1'b1;
    #1;
    checks++;
    if (ow_mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_cycle0_req: got %b want 0", ow_mem_req);
    end
    tick(); #1;
    checks++;
    if (ow_mem_req !== 1'b1 || ow_mem_addr !== 24'h0) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want 1/000000", ow_mem_req, ow_mem_addr);
    end
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b0 || ow_mem_addr !== 24'h1) begin
      errors++; $display("FAIL cycle2: valid=%b addr=%h want 0/000001", ow_valid, ow_mem_addr);
    end
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h0 || ow_instr !== 32'h100) begin
      errors++; $display("FAIL first_valid: valid=%b pc=%h instr=%h want 1/000000/00000100",
                         ow_valid, ow_pc, ow_instr);
    end
    for (int k = 1; k <= 6; k++) begin
      tick(); #1;
      checks++;
      if (ow_valid !== 1'b1 || ow_pc !== AW'(k) || ow_instr !== DW'(k + 32'h100) ||
          ow_mem_addr !== AW'(k + 2)) begin
        errors++; $display("FAIL stream k=%0d: valid=%b pc=%h instr=%h addr=%h",
                           k, ow_valid, ow_pc, ow_instr, ow_mem_addr);
      end
    end
  endtask

  task automatic test_stall();
    iw_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      checks++;
      if (ow_valid !== 1'b1 || ow_pc !== 24'h6 || ow_instr !== 32'h106) begin
        errors++; $display("FAIL stall_hold i=%0d: valid=%b pc=%h instr=%h want 1/000006/00000106",
                           i, ow_valid, ow_pc, ow_instr);
      end
    end
    checks++;
    if (ow_mem_req !== 1'b0 || ow_mem_addr !== 24'ha) begin
      errors++; $display("FAIL stall_credit: req=%b addr=%h want 0/00000a", ow_mem_req, ow_mem_addr);
    end
    iw_stall = 1'b0;
    for (int k = 7; k <= 14; k++) begin
      tick(); #1;
      checks++;
      if (ow_valid !== 1'b1 || ow_pc !== AW'(k) || ow_instr !== DW'(k + 32'h100)) begin
        errors++; $display("FAIL stall_resume k=%0d: valid=%b pc=%h instr=%h", k, ow_valid, ow_pc, ow_instr);
      end
    end
  endtask

  task automatic test_gnt_hold();
    do_reset(1, 1'b0);
    tick(); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ow_mem_req !== 1'b1 || ow_mem_addr !== 24'h0 || ow_valid !== 1'b0) begin
        errors++; $display("FAIL gnt_hold i=%0d: req=%b addr=%h valid=%b want 1/000000/0",
                           i, ow_mem_req, ow_mem_addr, ow_valid);
      end
      tick(); #1;
    end
    iw_mem_gnt = 1'b1;
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b0 || ow_mem_addr !== 24'h1) begin
      errors++; $display("FAIL gnt_accept: valid=%b addr=%h want 0/000001", ow_valid, ow_mem_addr);
    end
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h0 || ow_instr !== 32'h100) begin
      errors++; $display("FAIL gnt_first: valid=%b pc=%h instr=%h want 1/000000/00000100",
                         ow_valid, ow_pc, ow_instr);
    end
  endtask

  task automatic test_flush_drop();
    do_reset(3, 1'b1);
    tick(); tick(); tick(); #1;
    checks++;
    if (ow_mem_req !== 1'b0 || ow_mem_addr !== 24'h2) begin
      errors++; $display("FAIL outst_limit: req=%b addr=%h want 0/000002", ow_mem_req, ow_mem_addr);
    end
    iw_flush = 1'b1;
    iw_flush_pc = 24'h40;
    tick();
    iw_flush = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ow_valid !== 1'b0 || ow_mem_req !== 1'b0) begin
        errors++; $display("FAIL drop_wait i=%0d: valid=%b req=%b want 0/0", i, ow_valid, ow_mem_req);
      end
      tick(); #1;
    end
    checks++;
    if (ow_mem_req !== 1'b1 || ow_mem_addr !== 24'h40) begin
      errors++; $display("FAIL redirect_req: req=%b addr=%h want 1/000040", ow_mem_req, ow_mem_addr);
    end
    wait_valid(10);
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h40 || ow_instr !== 32'h140) begin
      errors++; $display("FAIL redirect_data: valid=%b pc=%h instr=%h want 1/000040/00000140",
                         ow_valid, ow_pc, ow_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b1);
    repeat (5) tick();
    iw_flush = 1'b1;
    iw_flush_pc = 24'hffffff;
    #1;
    checks++;
    if (ow_mem_req !== 1'b0) begin
      errors++; $display("FAIL flush_withdraw: req=%b want 0", ow_mem_req);
    end
    tick();
    iw_flush = 1'b0;
    #1;
    checks++;
    if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0) begin
      errors++; $display("FAIL flush_clear: valid=%b pc=%h instr=%h want 0/0/0", ow_valid, ow_pc, ow_instr);
    end
    wait_valid(10);
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'hffffff || ow_instr !== 32'h010000ff) begin
      errors++; $display("FAIL wrap0: valid=%b pc=%h instr=%h want 1/ffffff/010000ff", ow_valid, ow_pc, ow_instr);
    end
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h0 || ow_instr !== 32'h100) begin
      errors++; $display("FAIL wrap1: valid=%b pc=%h instr=%h want 1/000000/00000100", ow_valid, ow_pc, ow_instr);
    end
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h1 || ow_instr !== 32'h101) begin
      errors++; $display("FAIL wrap2: valid=%b pc=%h instr=%h want 1/000001/00000101", ow_valid, ow_pc, ow_instr);
    end
  endtask

  task automatic test_back_to_back();
    iw_flush = 1'b1;
    iw_flush_pc = 24'h200;
    tick();
    iw_flush_pc = 24'h300;
    tick();
    iw_flush = 1'b0;
    #1;
    wait_valid(10);
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h300 || ow_instr !== 32'h400) begin
      errors++; $display("FAIL b2b_flush: valid=%b pc=%h instr=%h want 1/000300/00000400", ow_valid, ow_pc, ow_instr);
    end
    tick(); #1;
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h301) begin
      errors++; $display("FAIL b2b_next: valid=%b pc=%h want 1/000301", ow_valid, ow_pc);
    end
  endtask

  task automatic test_flush_stall_full();
    iw_stall = 1'b1;
    repeat (8) tick();
    iw_flush = 1'b1;
    iw_flush_pc = 24'h80;
    tick();
    iw_flush = 1'b0;
    iw_stall = 1'b0;
    #1;
    checks++;
    if (ow_valid !== 1'b0 || ow_pc !== '0 || ow_instr !== '0) begin
      errors++; $display("FAIL flush_stall_clear: valid=%b pc=%h instr=%h want 0/0/0", ow_valid, ow_pc, ow_instr);
    end
    checks++;
    if (ow_mem_req !== 1'b1 || ow_mem_addr !== 24'h80) begin
      errors++; $display("FAIL flush_stall_req: req=%b addr=%h want 1/000080", ow_mem_req, ow_mem_addr);
    end
`ifdef STG_IF_PERF_EN
    bub_before = ow_perf_bubble;
`endif
    wait_valid(10);
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h80 || ow_instr !== 32'h180) begin
      errors++; $display("FAIL flush_stall_refill: valid=%b pc=%h instr=%h want 1/000080/00000180",
                         ow_valid, ow_pc, ow_instr);
    end
`ifdef STG_IF_PERF_EN
    checks++;
    if (ow_perf_bubble !== bub_before + 32'd2) begin
      errors++; $display("FAIL perf_bubble: got %0d want %0d", ow_perf_bubble, bub_before + 32'd2);
    end
    checks++;
    if (ow_perf_fetched !== 32'(pops)) begin
      errors++; $display("FAIL perf_fetched: got %0d want %0d", ow_perf_fetched, pops);
    end
`endif
  endtask

  task automatic test_reset_mid();
    tick();
    iw_rst_n = 1'b0;
    #1;
    checks++;
    if (ow_valid !== 1'b0 || ow_mem_req !== 1'b0 || ow_mem_addr !== '0 || ow_pc !== '0 || ow_instr !== '0) begin
      errors++; $display("FAIL reset_mid: valid=%b req=%b addr=%h pc=%h instr=%h want all 0",
                         ow_valid, ow_mem_req, ow_mem_addr, ow_pc, ow_instr);
    end
    mem_en = 1'b0;
    iw_mem_rvalid = 1'b0;
    tick();
    tick();
    iw_rst_n = 1'b1;
    iw_mem_rvalid = 1'b1;
    iw_mem_rdata = 32'hdead;
    tick();
    iw_mem_rvalid = 1'b0;
    mem_en = 1'b1;
    #1;
    checks++;
    if (ow_valid !== 1'b0) begin
      errors++; $display("FAIL stray_rvalid: valid=%b want 0", ow_valid);
    end
    tick(); tick(); #1;
    checks++;
    if (ow_valid !== 1'b1 || ow_pc !== 24'h0 || ow_instr !== 32'h100) begin
      errors++; $display("FAIL after_stray: valid=%b pc=%h instr=%h want 1/000000/00000100",
                         ow_valid, ow_pc, ow_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_gnt_hold();
    test_flush_drop();
    test_wrap();
    test_back_to_back();
    test_flush_stall_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
